piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: parallel word width, legal range 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-003 SHALL have parameter PARITY_EN, default 0: 1 = append one even-parity bit after the data bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (asserted when 0).
REQ-006 SHALL have port a, input, WIDTH bits: parallel word to serialize.
REQ-007 SHALL have port load, input, 1 bit: requester strobe; word a is valid while high.
REQ-008 SHALL have port ready, output, 1 bit: block can accept a word this cycle.
REQ-009 SHALL have port sout, output, 1 bit: serial data.
REQ-010 SHALL have port frame, output, 1 bit: high exactly while sout carries a data or parity bit.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on the final bit of each word.

Function
REQ-012 SHALL implement two states: IDLE and SHIFT.
REQ-013 SHALL accept a word on a rising edge where load=1 and ready=1 (handshake); load while ready=0 SHALL be ignored and not queued.
REQ-014 On acceptance SHALL register a into an internal shift register, clear the bit counter, and enter SHIFT.
REQ-015 Latency SHALL be one cycle: the first bit appears on sout, with frame=1, in the cycle after the accepting edge.
REQ-016 Bit order SHALL be a[WIDTH-1] down to a[0] when MSB_FIRST=1, and a[0] up to a[WIDTH-1] when MSB_FIRST=0.
REQ-017 When PARITY_EN=1, SHALL send, after the data bits, one bit equal to the XOR of the accepted word (even parity).
REQ-018 A frame SHALL last N cycles, where N = WIDTH + PARITY_EN; the counter SHALL run 0..N-1 and never wrap past N-1.
REQ-019 ready SHALL be 1 in IDLE and in the SHIFT cycle with counter = N-1; it SHALL be 0 in every other SHIFT cycle.
REQ-020 done SHALL be 1 only in the SHIFT cycle with counter = N-1.
REQ-021 On the edge that ends the last bit: if load=1, SHALL accept the new word and stay in SHIFT, with no gap cycle (back-to-back frames); otherwise SHALL go to IDLE.
REQ-022 In IDLE, sout SHALL be 0, frame SHALL be 0 and done SHALL be 0.
REQ-023 sout, frame and done SHALL be driven from registers or state only, never combinationally from a or load; ready MAY be decoded from state and counter.
REQ-024 Changes on a while no handshake is taking place SHALL NOT affect sout.

Reset
REQ-025 While rst=0, SHALL immediately force: state = IDLE, shift register = 0, counter = 0, sout = 0, frame = 0, done = 0, ready = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further bits; after release the block SHALL wait for a new handshake.
REQ-027 The first handshake SHALL be possible on the first rising edge after rst goes 1.

Verification
REQ-028 Defaults, a=4'b1011, load pulsed one cycle -> next 4 cycles: sout = 1,0,1,1; frame=1 throughout; done=1 only in the 4th cycle; then IDLE with sout=0, frame=0.
REQ-029 MSB_FIRST=0, a=4'b1011 -> sout = 1,1,0,1.
REQ-030 PARITY_EN=1, a=4'b0111 -> 5-cycle frame: sout = 0,1,1,1,1 (parity bit 1); done in the 5th cycle.
REQ-031 load held high with a=4'hA, then 4'h5 -> frames 1,0,1,0,0,1,0,1 with frame held high continuously; ready=1 only in the 4th and 8th bits.
REQ-032 load asserted in the 2nd bit of a frame -> ignored; the current frame completes unchanged and returns to IDLE.
REQ-033 rst driven to 0 in the middle of the 3rd bit -> sout, frame and done go 0 at once, ready goes 1; after release, a new load gives a clean frame.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a load/ready
// handshake and shifts it out one bit per cycle, optionally followed by even parity.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             frame,
    output logic             done
);

    localparam int N  = WIDTH + int'(PARITY_EN);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             par;
    logic             accept;
    logic             first_bit;
    logic             next_bit;

    // Handshake: a word transfers on a rising edge where load and ready are both 1;
    // load with ready low is dropped, never queued. ready also opens on the last bit
    // so a new word can follow with no gap cycle.
    assign ready     = (state == IDLE) || (cnt == LAST);
    assign accept    = load && ready;
    assign first_bit = MSB_FIRST ? a[WIDTH-1] : a[0];
    assign next_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    // shreg always holds the bits still to be sent, aligned so the next one sits at the output end
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) shift1 = {v[WIDTH-2:0], 1'b0};
        else           shift1 = {1'b0, v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            par   <= 1'b0;
            sout  <= 1'b0;
            frame <= 1'b0;
            done  <= 1'b0;
        end else if (accept) begin
            state <= SHIFT;
            shreg <= shift1(a);
            par   <= ^a;
            cnt   <= '0;
            sout  <= first_bit;
            frame <= 1'b1;
            done  <= 1'b0;
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
                sout  <= 1'b0;
                frame <= 1'b0;
                done  <= 1'b0;
            end else begin
                cnt  <= cnt + CW'(1);
                done <= ((cnt + CW'(1)) == LAST);
                if ((int'(cnt) + 1) < WIDTH) begin
                    sout  <= next_bit;
                    shreg <= shift1(shreg);
                end else begin
                    sout <= par;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: three instances cover MSB-first, LSB-first and parity
// variants; every cycle of each frame is checked against hand-computed bits.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [3:0] a_v [3];
    logic [2:0] load_v;
    logic [2:0] ready_v;
    logic [2:0] sout_v;
    logic [2:0] frame_v;
    logic [2:0] done_v;

    int vectors;
    int errors;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
        .clk(clk), .rst(rst), .a(a_v[0]), .load(load_v[0]),
        .ready(ready_v[0]), .sout(sout_v[0]), .frame(frame_v[0]), .done(done_v[0])
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .a(a_v[1]), .load(load_v[1]),
        .ready(ready_v[1]), .sout(sout_v[1]), .frame(frame_v[1]), .done(done_v[1])
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
        .clk(clk), .rst(rst), .a(a_v[2]), .load(load_v[2]),
        .ready(ready_v[2]), .sout(sout_v[2]), .frame(frame_v[2]), .done(done_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int d, input logic s, input logic f,
                           input logic dn, input logic r);
        chk({tag, ".sout"},  sout_v[d],  s);
        chk({tag, ".frame"}, frame_v[d], f);
        chk({tag, ".done"},  done_v[d],  dn);
        chk({tag, ".ready"}, ready_v[d], r);
    endtask

    // Load one word with a single-cycle strobe and check every bit of the frame, then IDLE.
    task automatic send(input string tag, input int d, input logic [3:0] word,
                        input logic [4:0] exp_bits, input int n);
        a_v[d]    = word;
        load_v[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) load_v[d] = 1'b0;
            chk_out($sformatf("%s.bit%0d", tag, i), d, exp_bits[n-1-i], 1'b1,
                    i == n - 1, i == n - 1);
        end
        tick();
        chk_out({tag, ".idle"}, d, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b0;
        load_v  = '0;
        for (int d = 0; d < 3; d++) a_v[d] = 4'h0;

        // Reset state
        tick();
        for (int d = 0; d < 3; d++) chk_out($sformatf("reset%0d", d), d, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;

        // First handshake on the first edge after release
        send("msb_1011", 0, 4'b1011, 5'b01011, 4);
        send("lsb_1011", 1, 4'b1011, 5'b01101, 4);
        send("par_0111", 2, 4'b0111, 5'b01111, 5);
        send("par_0110", 2, 4'b0110, 5'b01100, 5);

        // Changes on a with no handshake leave sout quiet
        a_v[0] = 4'hF;
        tick();
        chk_out("idle_a_change", 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back frames: 4'hA then 4'h5 with load held high
        a_v[0]    = 4'hA;
        load_v[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_bits;
            exp_bits = 8'b1010_0101;
            tick();
            if (i == 0) a_v[0] = 4'h5;
            if (i == 4) load_v[0] = 1'b0;
            chk_out($sformatf("b2b.bit%0d", i), 0, exp_bits[7-i], 1'b1,
                    (i == 3) || (i == 7), (i == 3) || (i == 7));
        end
        tick();
        chk_out("b2b.idle", 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // load during the 2nd bit is ignored; the frame completes unchanged
        a_v[0]    = 4'b1011;
        load_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_bits;
            exp_bits = 4'b1011;
            tick();
            if (i == 0) load_v[0] = 1'b0;
            if (i == 1) begin
                a_v[0]    = 4'b0100;
                load_v[0] = 1'b1;
            end
            if (i == 2) load_v[0] = 1'b0;
            chk_out($sformatf("ign.bit%0d", i), 0, exp_bits[3-i], 1'b1, i == 3, i == 3);
        end
        tick();
        chk_out("ign.idle", 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of the 3rd bit aborts the frame at once
        a_v[0]    = 4'b1011;
        load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        chk_out("rst.bit0", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("rst.bit2", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("rst.abort", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk_out("rst.after", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        send("rst.clean", 0, 4'b0110, 5'b00110, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
